serial_adder: RTL and testbench

- Bit-serial N-bit adder: the additive counterpart of the team's full-subtractor cell.
- Adds two latched operands plus carry-in, LSB first, one bit per clock, through a single full-adder cell with a registered carry.
- Sits beside the subtractor blocks as the area-minimal arithmetic unit for datapaths that trade latency for gates.
- Uses a start/busy/done handshake.

---
 rtl/arith_pkg.sv | 13 +
 rtl/fa_cell.sv | 16 +
 rtl/serial_adder.sv | 117 +++++++++++
 tb/tb_serial_adder.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/arith_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks (adder now,
// subtractor/ALU later).
package arith_pkg;

   localparam int DEFAULT_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/fa_cell.sv
// Single-bit full adder; the only arithmetic in the serial adder.
module fa_cell (
   input  logic A,
   input  logic B,
   input  logic C,
   output logic Sum,
   output logic Carry
);

   // sum and carry of three one-bit inputs
   always_comb begin
      Sum   = A ^ B ^ C;
      Carry = (A & B) | (C & (A ^ B));
   end

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: {cout,sum} = a + b + cin, LSB first, one bit per clock.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start; sum/cout hold the last result
// RUN   | one operand bit pair per edge through fa_cell
// DONE  | one-cycle done pulse; start here chains the next operation
module serial_adder
   import arith_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_t           state;
   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   // holds the WIDTH-1 bits produced so far; the last bit goes straight to sum
   logic [WIDTH-2:0] res_sr;
   logic             carry;
   logic [CW-1:0]    cnt;
   logic             s_bit;
   logic             c_next;
   logic [WIDTH-1:0] res_next;

   fa_cell u_fa (
      .A     (a_sr[0]),
      .B     (b_sr[0]),
      .C     (carry),
      .Sum   (s_bit),
      .Carry (c_next)
   );

   // result register with the current bit shifted in at the top
   always_comb begin
      res_next = {s_bit, res_sr};
   end

   // control FSM, operand/result shifting and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         a_sr   <= '0;
         b_sr   <= '0;
         res_sr <= '0;
         carry  <= 1'b0;
         cnt    <= '0;
         busy   <= 1'b0;
         done   <= 1'b0;
         sum    <= '0;
         cout   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  a_sr   <= a;
                  b_sr   <= b;
                  carry  <= cin;
                  res_sr <= '0;
                  cnt    <= '0;
                  busy   <= 1'b1;
                  state  <= RUN;
               end
            end
            RUN: begin
               a_sr   <= a_sr >> 1;
               b_sr   <= b_sr >> 1;
               res_sr <= res_next[WIDTH-1:1];
               carry  <= c_next;
               if (cnt == LAST) begin
                  sum   <= res_next;
                  cout  <= c_next;
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  state <= DONE;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            DONE: begin
               done <= 1'b0;
               if (start) begin
                  a_sr   <= a;
                  b_sr   <= b;
                  carry  <= cin;
                  res_sr <= '0;
                  cnt    <= '0;
                  busy   <= 1'b1;
                  state  <= RUN;
               end else begin
                  state <= IDLE;
               end
            end
            default: begin
               busy  <= 1'b0;
               done  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_adder.sv
// Directed and random checks of serial_adder at WIDTH=8 and WIDTH=5.
module tb_serial_adder;

   logic       clk = 1'b0;
   logic       rst = 1'b1;

   logic       start8 = 1'b0;
   logic [7:0] a8 = '0;
   logic [7:0] b8 = '0;
   logic       cin8 = 1'b0;
   logic       busy8;
   logic       done8;
   logic [7:0] sum8;
   logic       cout8;

   logic       start5 = 1'b0;
   logic [4:0] a5 = '0;
   logic [4:0] b5 = '0;
   logic       cin5 = 1'b0;
   logic       busy5;
   logic       done5;
   logic [4:0] sum5;
   logic       cout5;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   serial_adder #(.WIDTH(8)) u_dut8 (
      .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
      .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
   );

   serial_adder #(.WIDTH(5)) u_dut5 (
      .clk(clk), .rst(rst), .start(start5), .a(a5), .b(b5), .cin(cin5),
      .busy(busy5), .done(done5), .sum(sum5), .cout(cout5)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One WIDTH=8 operation. If chained, the caller is at the negedge of the
   // previous done cycle and start is driven there. Checks busy for cycles
   // 1..8, the held previous result, done after edge 8, and the falling done.
   task automatic run8(input string tag, input logic [7:0] ta, input logic [7:0] tb,
                       input logic tc, input logic [7:0] exp_s, input logic exp_c,
                       input logic [7:0] prev_s, input logic prev_c,
                       input bit chained, input bit check_fall);
      if (!chained) @(negedge clk);
      a8 = ta; b8 = tb; cin8 = tc; start8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0;
      for (int k = 0; k < 8; k++) begin
         check({tag, "_busy"}, busy8, 1);
         check({tag, "_nodone"}, done8, 0);
         check({tag, "_hold"}, {cout8, sum8}, {prev_c, prev_s});
         @(negedge clk);
      end
      check({tag, "_done"}, done8, 1);
      check({tag, "_idle"}, busy8, 0);
      check({tag, "_sum"}, {cout8, sum8}, {exp_c, exp_s});
      if (check_fall) begin
         @(negedge clk);
         check({tag, "_fall"}, done8, 0);
      end
   endtask

   initial begin
      int guard;
      logic [8:0] exp9;
      logic [5:0] exp6;

      // reset state
      repeat (2) @(negedge clk);
      check("rst_busy", busy8, 0);
      check("rst_done", done8, 0);
      check("rst_sum", sum8, 0);
      check("rst_cout", cout8, 0);
      rst = 1'b0;
      @(negedge clk);
      check("idle_done", done8, 0);

      run8("t1", 8'h3C, 8'h0F, 1'b0, 8'h4B, 1'b0, 8'h00, 1'b0, 0, 1);
      run8("t2", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 8'h4B, 1'b0, 0, 1);
      run8("t3", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 8'h00, 1'b1, 0, 1);

      // start held high and operands changed during RUN
      @(negedge clk);
      a8 = 8'h10; b8 = 8'h20; cin8 = 1'b0; start8 = 1'b1;
      @(negedge clk);
      a8 = 8'h55; b8 = 8'h55; cin8 = 1'b1;
      for (int k = 0; k < 8; k++) begin
         check("held_busy", busy8, 1);
         check("held_nodone", done8, 0);
         @(negedge clk);
      end
      check("held_done", done8, 1);
      check("held_sum", {cout8, sum8}, {1'b0, 8'h30});
      start8 = 1'b0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         check("held_single_done", done8, 0);
      end

      // reset at edge 4 of an operation
      a8 = 8'h77; b8 = 8'h11; cin8 = 1'b0; start8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("abort_busy", busy8, 0);
      check("abort_done", done8, 0);
      check("abort_sum", {cout8, sum8}, 0);
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         check("abort_nodone", done8, 0);
      end
      run8("t5", 8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 8'h00, 1'b0, 0, 1);

      // back-to-back: second start in the DONE cycle
      run8("t6a", 8'h3C, 8'h0F, 1'b1, 8'h4C, 1'b0, 8'h02, 1'b0, 0, 0);
      run8("t6b", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 8'h4C, 1'b0, 1, 1);

      // random sweep, WIDTH=8
      for (int i = 0; i < 500; i++) begin
         @(negedge clk);
         a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
         exp9 = {1'b0, a8} + {1'b0, b8} + {8'd0, cin8};
         start8 = 1'b1;
         @(negedge clk);
         start8 = 1'b0;
         guard = 0;
         while (!done8 && guard < 20) begin
            @(negedge clk);
            guard++;
         end
         check("rnd8_done", done8, 1);
         check("rnd8_sum", {cout8, sum8}, exp9);
         @(negedge clk);
         check("rnd8_pulse", done8, 0);
      end

      // random sweep, WIDTH=5
      for (int i = 0; i < 500; i++) begin
         @(negedge clk);
         a5 = 5'($urandom); b5 = 5'($urandom); cin5 = 1'($urandom);
         exp6 = {1'b0, a5} + {1'b0, b5} + {5'd0, cin5};
         start5 = 1'b1;
         @(negedge clk);
         start5 = 1'b0;
         guard = 0;
         while (!done5 && guard < 20) begin
            @(negedge clk);
            guard++;
         end
         check("rnd5_done", done5, 1);
         check("rnd5_sum", {cout5, sum5}, exp6);
         @(negedge clk);
         check("rnd5_pulse", done5, 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
